calc_port_scheduler: RTL and testbench
======================================

// Module: calc_port_scheduler
// PURPOSE
//  Front end of calc1: captures the two-cycle command protocol (cmd+op1, then op2) on 4 requester ports.
//  Shares one ALU between the ports by round-robin and returns each result on the originating port's resp/data.
//  Invalid commands are answered locally without using the ALU; a hung ALU is bounded by a timeout.
// PARAMETERS
//  NUM_PORTS    4    requester ports; the RTL supports 4 only and asserts on any other value
//  DATA_W       32   operand/result width
//  ALU_TIMEOUT  64   cycles allowed from alu_ack to alu_done before a forced error response
// PORTS
//  c_clk         in   1        single clock, all state on posedge
//  reset         in   1        asynchronous, active-low; all state clears while low
//  req_cmd_in    in   4x4      per-port cmd: 0 nop, 1 add, 2 sub, 5 shl, 6 shr, others invalid
//  req_data_in   in   4xDATA_W per-port operand: op1 with cmd, op2 on the following cycle
//  out_resp      out  4x2      per-port resp: 00 none, 01 ok, 10 overflow/underflow, 11 invalid/timeout
//  out_data      out  4xDATA_W per-port result; valid only while out_resp==01, else 0
//  alu_req       out  1        request to the shared ALU; held until alu_ack
//  alu_cmd       out  4        granted command, stable while alu_req=1
//  alu_op1       out  DATA_W   granted op1, stable while alu_req=1
//  alu_op2       out  DATA_W   granted op2, stable while alu_req=1
//  alu_ack       in   1        ALU accepted the request (sampled with alu_req=1)
//  alu_done      in   1        one-cycle pulse: result ready
//  alu_resp      in   2        ALU response code, valid with alu_done
//  alu_data      in   DATA_W   ALU result, valid with alu_done
//  busy          out  1        scheduler not in S_IDLE, or any port not in P_IDLE
// BEHAVIOUR
//  Reset: out_resp=0, out_data=0, alu_req=0, alu_cmd/op1/op2=0, busy=0; all ports P_IDLE; scheduler S_IDLE; rr pointer=0.
//  Per-port FSM
//   P_IDLE: cmd!=0 at an edge -> capture cmd and op1 -> P_OP2.
//   P_OP2: next edge, capture req_data_in as op2 -> P_PEND. A nonzero cmd in this cycle is ignored.
//   P_PEND: wait for grant. Commands arriving in P_OP2, P_PEND or P_ACTIVE are dropped silently; no response, no queueing.
//   P_ACTIVE: entered on grant. On the edge that launches the response -> P_IDLE.
//   A cmd present in the response cycle is therefore accepted.
//  Scheduler FSM
//   S_IDLE: any P_PEND at an edge -> grant the first pending port searching from rr pointer.
//    rr pointer <= granted+1 (mod 4).
//    Valid cmd -> S_ISSUE. Invalid cmd -> S_RESP with resp 11, data 0.
//   S_ISSUE: alu_req=1 and operands driven from the same edge; alu_ack at an edge -> S_WAIT with timeout counter=0.
//   S_WAIT: alu_done at an edge -> latch alu_resp/alu_data -> S_RESP.
//    Counter reaches ALU_TIMEOUT -> S_RESP with resp 11, data 0.
//    alu_done arriving in the same cycle as the timeout wins.
//   S_RESP: out_resp/out_data of the granted port driven for exactly one cycle; all other ports 00/0; -> S_IDLE.
//  out_data is forced to 0 unless the resp is 01, even if the ALU drives data.
//  Latency, ALU acking and completing in the cycle after request:
//   cmd at edge T, op2 at T+1, grant T+2, ack T+3, done T+4, resp visible T+4 to T+5.
//   Best case, invalid cmd: resp visible T+3 to T+4.
//  Fairness: among ports continuously pending, each is served at most once per 4 grants.
//  Stray alu_ack or alu_done outside S_ISSUE/S_WAIT is ignored.
//  Reset low mid-operation: immediate clear, in-flight requests lost, no response. The ALU is reset by the same signal.
//  All outputs are registered; no combinational path from any input to any output.
// STRUCTURE
//  calc_pkg: cmd_e (NOP/ADD/SUB/SHL/SHR), resp_e (NONE/OK/ERR/INV), port_state_e, sched_state_e, NUM_PORTS, cmd_valid() function.
//  Sub-module calc_rr_arbiter: 4-bit pending vector + pointer -> one-hot grant, index, any_valid; purely combinational.
//  Per-port capture FSMs in a generate loop; one scheduler FSM plus timeout counter in the top.
// TESTING (ALU model with configurable ack/done delay)
//  1. Port 1 cmd=1 op1=0x64 op2=0x27, ALU returns 01/0x8B -> port 1 resp=01 data=0x8B for exactly one cycle; ports 2-4 stay 00.
//  2. All 4 ports issue cmd=1 in the same cycle; rr pointer=0 -> responses in port order 1,2,3,4.
//     Second burst after rr pointer advanced -> order continues round-robin, no port served twice.
//  3. Port 3 cmd=0xF op1=5 op2=6 -> resp=11 data=0; alu_req never asserted.
//  4. ALU acks but never sends done (ALU_TIMEOUT=64) -> resp=11 exactly 64 cycles after ack; next pending port is then served.
//  5. Port 2 sends cmd=2 while its previous request is pending -> only one response arrives.
//     A new cmd in the response cycle is accepted and answered.
//  6. reset driven low while in S_WAIT -> all outputs 0 immediately, no late response after release.
//     A fresh cmd=5 op1=3 op2=2 -> resp=01 data=0xC.

Source files
------------

// File: rtl/calc_port_scheduler_pkg.sv
// calc1 port scheduler: shared types and helpers.
// Command/response encodings and FSM state types.
package calc_port_scheduler_pkg;

  localparam int NUM_PORTS = 4;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_OK   = 2'b01,
    RESP_ERR  = 2'b10,
    RESP_INV  = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_OP2,
    P_PEND,
    P_ACTIVE
  } port_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } sched_state_e;

  function automatic logic cmd_valid(input logic [3:0] c);
    logic v;
    v = 1'b0;
    case (c)
      CMD_ADD, CMD_SUB,
      CMD_SHL, CMD_SHR: v = 1'b1;
      default:          v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/calc_port_scheduler_if.sv
// calc1 port scheduler: shared ALU request/response bus.
// master = scheduler, slave = ALU.
interface calc_port_scheduler_if #(
  parameter int DATA_W = 32
);

  logic              alu_req;
  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] alu_op1;
  logic [DATA_W-1:0] alu_op2;
  logic              alu_ack;
  logic              alu_done;
  logic [1:0]        alu_resp;
  logic [DATA_W-1:0] alu_data;

  modport master (
    output alu_req, alu_cmd, alu_op1, alu_op2,
    input  alu_ack, alu_done, alu_resp, alu_data
  );

  modport slave (
    input  alu_req, alu_cmd, alu_op1, alu_op2,
    output alu_ack, alu_done, alu_resp, alu_data
  );

endinterface

// File: rtl/calc_port_scheduler_rr_arbiter.sv
// calc1 port scheduler: 4-way round-robin picker.
// First pending port at or after ptr wins.
module calc_port_scheduler_rr_arbiter (
  input  logic [3:0] pend,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       any_valid
);

  // scan the four ports starting at the pointer, wrapping
  always_comb begin
    logic [1:0] j;
    gnt       = '0;
    gnt_idx   = '0;
    any_valid = 1'b0;
    j         = '0;
    for (int i = 0; i < 4; i++) begin
      j = ptr + 2'(i);
      if (!any_valid && pend[j]) begin
        any_valid = 1'b1;
        gnt_idx   = j;
        gnt[j]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_port_scheduler.sv
// calc1 front end: per-port two-cycle capture, round-robin
// sharing of one ALU, local invalid replies, ALU timeout.
module calc_port_scheduler #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_W      = 32,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic                             c_clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0][3:0]        req_cmd_in,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] req_data_in,
  output logic [NUM_PORTS-1:0][1:0]        out_resp,
  output logic [NUM_PORTS-1:0][DATA_W-1:0] out_data,
  calc_port_scheduler_if.master            alu,
  output logic                             busy
);

  import calc_port_scheduler_pkg::*;

  if (NUM_PORTS != 4) begin : g_np_check
    $error("calc_port_scheduler supports NUM_PORTS=4 only");
  end

  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

  sched_state_e      sched;
  logic [1:0]        rr_ptr;
  logic [1:0]        act_idx;
  logic              inv_pend;
  logic [CNT_W-1:0]  tmo_cnt;

  logic [NUM_PORTS-1:0]             pend;
  logic [NUM_PORTS-1:0]             port_idle;
  logic [NUM_PORTS-1:0][3:0]        cmd_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0] op1_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0] op2_v;

  logic [3:0] gnt_oh;
  logic [1:0] gnt_idx;
  logic       gnt_any;
  logic       grant_fire;
  logic       tmo_hit;
  logic       launch;

  calc_port_scheduler_rr_arbiter u_arb (
    .pend      (pend),
    .ptr       (rr_ptr),
    .gnt       (gnt_oh),
    .gnt_idx   (gnt_idx),
    .any_valid (gnt_any)
  );

  assign grant_fire = (sched == S_IDLE) && gnt_any;
  assign tmo_hit    = tmo_cnt == CNT_W'(ALU_TIMEOUT - 1);
  assign launch     = ((sched == S_WAIT) && (alu.alu_done || tmo_hit))
                   || ((sched == S_RESP) && inv_pend);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    port_state_e       st;
    logic [3:0]        cmd_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;

    // capture cmd+op1, then op2; hold until the response launches
    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        st    <= P_IDLE;
        cmd_q <= '0;
        op1_q <= '0;
        op2_q <= '0;
      end else begin
        unique case (st)
          P_IDLE: begin
            if (req_cmd_in[i] != 4'd0) begin
              cmd_q <= req_cmd_in[i];
              op1_q <= req_data_in[i];
              st    <= P_OP2;
            end
          end
          P_OP2: begin
            op2_q <= req_data_in[i];
            st    <= P_PEND;
          end
          P_PEND: begin
            if (grant_fire && gnt_oh[i])
              st <= P_ACTIVE;
          end
          P_ACTIVE: begin
            if (launch && (act_idx == 2'(i)))
              st <= P_IDLE;
          end
        endcase
      end
    end

    assign pend[i]      = st == P_PEND;
    assign port_idle[i] = st == P_IDLE;
    assign cmd_v[i]     = cmd_q;
    assign op1_v[i]     = op1_q;
    assign op2_v[i]     = op2_q;
  end

  // scheduler: grant, issue to ALU, wait/timeout, one-cycle reply
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      sched        <= S_IDLE;
      rr_ptr       <= '0;
      act_idx      <= '0;
      inv_pend     <= 1'b0;
      tmo_cnt      <= '0;
      alu.alu_req  <= 1'b0;
      alu.alu_cmd  <= '0;
      alu.alu_op1  <= '0;
      alu.alu_op2  <= '0;
      out_resp     <= '0;
      out_data     <= '0;
    end else begin
      unique case (sched)
        S_IDLE: begin
          if (gnt_any) begin
            act_idx <= gnt_idx;
            rr_ptr  <= gnt_idx + 2'd1;
            if (cmd_valid(cmd_v[gnt_idx])) begin
              alu.alu_req <= 1'b1;
              alu.alu_cmd <= cmd_v[gnt_idx];
              alu.alu_op1 <= op1_v[gnt_idx];
              alu.alu_op2 <= op2_v[gnt_idx];
              sched       <= S_ISSUE;
            end else begin
              inv_pend <= 1'b1;
              sched    <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          if (alu.alu_ack) begin
            alu.alu_req <= 1'b0;
            tmo_cnt     <= '0;
            sched       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (alu.alu_done) begin
            out_resp[act_idx] <= alu.alu_resp;
            out_data[act_idx] <= (alu.alu_resp == RESP_OK)
                               ? alu.alu_data : '0;
            sched             <= S_RESP;
          end else if (tmo_hit) begin
            out_resp[act_idx] <= RESP_INV;
            out_data[act_idx] <= '0;
            sched             <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (inv_pend) begin
            inv_pend          <= 1'b0;
            out_resp[act_idx] <= RESP_INV;
            out_data[act_idx] <= '0;
          end else begin
            out_resp <= '0;
            out_data <= '0;
            sched    <= S_IDLE;
          end
        end
      endcase
    end
  end

  // any activity anywhere in the block
  assign busy = (sched != S_IDLE) || (port_idle != '1);

endmodule

// File: tb/tb_calc_port_scheduler.sv
// Directed bench for calc_port_scheduler.
// Behavioural ALU with adjustable ack/done delay.
module tb_calc_port_scheduler;

  logic              c_clk = 1'b0;
  logic              reset = 1'b0;
  logic [3:0][3:0]   req_cmd_in = '0;
  logic [3:0][31:0]  req_data_in = '0;
  logic [3:0][1:0]   out_resp;
  logic [3:0][31:0]  out_data;
  logic              busy;

  calc_port_scheduler_if #(.DATA_W(32)) alu_if ();

  calc_port_scheduler #(
    .NUM_PORTS   (4),
    .DATA_W      (32),
    .ALU_TIMEOUT (64)
  ) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .alu         (alu_if),
    .busy        (busy)
  );

  always #5 c_clk = ~c_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit req_seen = 1'b0;

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } rsp_t;
  rsp_t rq[$];

  bit hang_once = 1'b0;
  bit hang_all  = 1'b0;
  bit force_err = 1'b0;
  int ack_dly   = 0;
  int done_dly  = 0;

  function automatic logic [31:0] alu_calc(
    input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  // ALU model
  initial begin
    int st = 0;
    int k = 0;
    logic [3:0]  c;
    logic [31:0] a, b;
    c = '0; a = '0; b = '0;
    alu_if.alu_ack  = 1'b0;
    alu_if.alu_done = 1'b0;
    alu_if.alu_resp = 2'b00;
    alu_if.alu_data = '0;
    forever begin
      @(posedge c_clk); #1;
      alu_if.alu_ack  = 1'b0;
      alu_if.alu_done = 1'b0;
      if (!reset) begin
        st = 0; k = 0;
      end else if (st == 0) begin
        if (alu_if.alu_req) begin
          if (k == ack_dly) begin
            alu_if.alu_ack = 1'b1;
            c = alu_if.alu_cmd; a = alu_if.alu_op1; b = alu_if.alu_op2;
            k = 0; st = 1;
          end else k++;
        end
      end else begin
        if (hang_once || hang_all) begin
          hang_once = 1'b0; st = 0;
        end else if (k == done_dly) begin
          alu_if.alu_done = 1'b1;
          alu_if.alu_resp = force_err ? 2'b10 : 2'b01;
          alu_if.alu_data = force_err ? 32'hDEAD : alu_calc(c, a, b);
          k = 0; st = 0;
        end else k++;
      end
    end
  end

  // response monitor
  initial begin
    forever begin
      @(posedge c_clk);
      cyc++;
      #1;
      if (alu_if.alu_req) req_seen = 1'b1;
      for (int p = 0; p < 4; p++)
        if (out_resp[p] != 2'b00)
          rq.push_back('{p, out_resp[p], out_data[p], cyc});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge c_clk); #2;
  endtask

  task automatic wait_rsp(input int n, input int limit, input string nm);
    int k = 0;
    while (rq.size() < n && k < limit) begin tick(); k++; end
    checks++;
    if (rq.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d responses, need %0d", nm, rq.size(), n);
    end
  endtask

  task automatic apply_reset();
    req_cmd_in = '0; req_data_in = '0;
    hang_once = 0; hang_all = 0; force_err = 0; ack_dly = 0; done_dly = 0;
    reset = 1'b0;
    repeat (2) @(posedge c_clk);
    #2 reset = 1'b1;
    rq.delete();
    req_seen = 1'b0;
  endtask

  task automatic send1(input int p, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    req_cmd_in[p] = c; req_data_in[p] = a;
    tick();
    req_cmd_in[p] = 4'd0; req_data_in[p] = b;
    tick();
    req_data_in[p] = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_resp !== '0) begin errors++; $display("FAIL rst_resp got %h exp 0", out_resp); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", out_data); end
    apply_reset();
    checks++; if (alu_if.alu_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", alu_if.alu_req); end
    checks++;
    if ({alu_if.alu_cmd, alu_if.alu_op1, alu_if.alu_op2} !== '0) begin
      errors++; $display("FAIL rst_aluops got %h/%h/%h exp 0", alu_if.alu_cmd, alu_if.alu_op1, alu_if.alu_op2);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
  endtask

  task automatic test_single();
    int t;
    rq.delete();
    t = cyc + 1;
    send1(0, 4'd1, 32'h64, 32'h27);
    tick();
    checks++; if (alu_if.alu_req !== 1'b1) begin errors++; $display("FAIL s_req got %b exp 1", alu_if.alu_req); end
    checks++; if (alu_if.alu_cmd !== 4'd1) begin errors++; $display("FAIL s_cmd got %h exp 1", alu_if.alu_cmd); end
    checks++; if (alu_if.alu_op1 !== 32'h64) begin errors++; $display("FAIL s_op1 got %h exp 64", alu_if.alu_op1); end
    checks++; if (alu_if.alu_op2 !== 32'h27) begin errors++; $display("FAIL s_op2 got %h exp 27", alu_if.alu_op2); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL s_busy got %b exp 1", busy); end
    wait_rsp(1, 10, "single");
    if (rq.size() > 0) begin
      checks++; if (rq[0].port !== 0) begin errors++; $display("FAIL s_port got %0d exp 0", rq[0].port); end
      checks++; if (rq[0].resp !== 2'b01) begin errors++; $display("FAIL s_resp got %b exp 01", rq[0].resp); end
      checks++; if (rq[0].data !== 32'h8B) begin errors++; $display("FAIL s_data got %h exp 8b", rq[0].data); end
      checks++; if (rq[0].cyc !== t + 4) begin errors++; $display("FAIL s_lat got %0d exp %0d", rq[0].cyc, t + 4); end
    end
    repeat (5) tick();
    checks++; if (rq.size() !== 1) begin errors++; $display("FAIL s_once got %0d exp 1", rq.size()); end
  endtask

  task automatic burst();
    for (int p = 0; p < 4; p++) begin
      req_cmd_in[p] = 4'd1; req_data_in[p] = 32'h10 * (p + 1);
    end
    tick();
    for (int p = 0; p < 4; p++) begin
      req_cmd_in[p] = 4'd0; req_data_in[p] = p + 1;
    end
    tick();
    req_data_in = '0;
  endtask

  task automatic test_round_robin();
    int exp_p;
    apply_reset();
    burst();
    wait_rsp(4, 60, "rr1");
    for (int i = 0; i < 4; i++) if (rq.size() > i) begin
      checks++; if (rq[i].port !== i) begin errors++; $display("FAIL rr1_order[%0d] got %0d exp %0d", i, rq[i].port, i); end
      checks++;
      if (rq[i].data !== 32'h10 * (i + 1) + i + 1) begin
        errors++; $display("FAIL rr1_data[%0d] got %h exp %h", i, rq[i].data, 32'h10 * (i + 1) + i + 1);
      end
    end
    tick(); rq.delete();
    send1(1, 4'd2, 32'd9, 32'd4);
    wait_rsp(1, 10, "rr_adv");
    tick(); tick(); rq.delete();
    burst();
    wait_rsp(4, 60, "rr2");
    for (int i = 0; i < 4; i++) if (rq.size() > i) begin
      exp_p = (i + 2) % 4;
      checks++; if (rq[i].port !== exp_p) begin errors++; $display("FAIL rr2_order[%0d] got %0d exp %0d", i, rq[i].port, exp_p); end
    end
    repeat (5) tick();
    checks++; if (rq.size() !== 4) begin errors++; $display("FAIL rr2_count got %0d exp 4", rq.size()); end
  endtask

  task automatic test_invalid();
    int t;
    rq.delete(); req_seen = 1'b0;
    t = cyc + 1;
    send1(2, 4'hF, 32'd5, 32'd6);
    wait_rsp(1, 10, "inv");
    if (rq.size() > 0) begin
      checks++; if (rq[0].port !== 2) begin errors++; $display("FAIL inv_port got %0d exp 2", rq[0].port); end
      checks++; if (rq[0].resp !== 2'b11) begin errors++; $display("FAIL inv_resp got %b exp 11", rq[0].resp); end
      checks++; if (rq[0].data !== 32'h0) begin errors++; $display("FAIL inv_data got %h exp 0", rq[0].data); end
      checks++; if (rq[0].cyc !== t + 3) begin errors++; $display("FAIL inv_lat got %0d exp %0d", rq[0].cyc, t + 3); end
    end
    repeat (3) tick();
    checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL inv_noreq got %b exp 0", req_seen); end
    checks++; if (rq.size() !== 1) begin errors++; $display("FAIL inv_once got %0d exp 1", rq.size()); end
  endtask

  task automatic test_timeout();
    int t;
    rq.delete();
    hang_once = 1'b1;
    t = cyc + 1;
    req_cmd_in[0] = 4'd1; req_data_in[0] = 32'd7;
    req_cmd_in[1] = 4'd2; req_data_in[1] = 32'd50;
    tick();
    req_cmd_in = '0;
    req_data_in[0] = 32'd8; req_data_in[1] = 32'd20;
    tick();
    req_data_in = '0;
    wait_rsp(1, 100, "tmo");
    if (rq.size() > 0) begin
      checks++; if (rq[0].port !== 0) begin errors++; $display("FAIL tmo_port got %0d exp 0", rq[0].port); end
      checks++; if (rq[0].resp !== 2'b11) begin errors++; $display("FAIL tmo_resp got %b exp 11", rq[0].resp); end
      checks++; if (rq[0].cyc !== t + 67) begin errors++; $display("FAIL tmo_lat got %0d exp %0d", rq[0].cyc, t + 67); end
    end
    wait_rsp(2, 20, "tmo_next");
    if (rq.size() > 1) begin
      checks++; if (rq[1].port !== 1) begin errors++; $display("FAIL tmo_nport got %0d exp 1", rq[1].port); end
      checks++; if (rq[1].data !== 32'd30) begin errors++; $display("FAIL tmo_ndata got %0d exp 30", rq[1].data); end
      checks++; if (rq[1].cyc !== t + 71) begin errors++; $display("FAIL tmo_nlat got %0d exp %0d", rq[1].cyc, t + 71); end
    end
    tick(); tick();
  endtask

  task automatic test_drop_and_resp_cycle();
    int r;
    rq.delete();
    req_cmd_in[1] = 4'd2; req_data_in[1] = 32'd10;
    tick();
    req_data_in[1] = 32'd3;
    tick();
    req_data_in[1] = 32'd99;
    tick();
    req_data_in[1] = 32'd77;
    tick();
    req_cmd_in[1] = 4'd0; req_data_in[1] = '0;
    wait_rsp(1, 10, "drop");
    r = cyc;
    req_cmd_in[1] = 4'd1; req_data_in[1] = 32'd20;
    tick();
    req_cmd_in[1] = 4'd0; req_data_in[1] = 32'd22;
    tick();
    req_data_in[1] = '0;
    if (rq.size() > 0) begin
      checks++; if (rq[0].data !== 32'd7) begin errors++; $display("FAIL drop_data got %0d exp 7", rq[0].data); end
    end
    wait_rsp(2, 10, "resp_cycle");
    if (rq.size() > 1) begin
      checks++; if (rq[1].port !== 1) begin errors++; $display("FAIL rc_port got %0d exp 1", rq[1].port); end
      checks++; if (rq[1].data !== 32'd42) begin errors++; $display("FAIL rc_data got %0d exp 42", rq[1].data); end
      checks++; if (rq[1].cyc !== r + 5) begin errors++; $display("FAIL rc_lat got %0d exp %0d", rq[1].cyc, r + 5); end
    end
    repeat (10) tick();
    checks++; if (rq.size() !== 2) begin errors++; $display("FAIL drop_count got %0d exp 2", rq.size()); end
  endtask

  task automatic test_alu_error();
    rq.delete();
    force_err = 1'b1; ack_dly = 2; done_dly = 3;
    send1(3, 4'd2, 32'd9, 32'd4);
    wait_rsp(1, 20, "err");
    if (rq.size() > 0) begin
      checks++; if (rq[0].resp !== 2'b10) begin errors++; $display("FAIL err_resp got %b exp 10", rq[0].resp); end
      checks++; if (rq[0].data !== 32'h0) begin errors++; $display("FAIL err_data got %h exp 0", rq[0].data); end
    end
    force_err = 1'b0; ack_dly = 0; done_dly = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int t;
    rq.delete();
    hang_all = 1'b1;
    send1(0, 4'd1, 32'd1, 32'd1);
    repeat (3) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (alu_if.alu_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b exp 0", alu_if.alu_req); end
    checks++; if (out_resp !== '0) begin errors++; $display("FAIL mid_resp got %h exp 0", out_resp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy0 got %b exp 0", busy); end
    tick(); tick();
    reset = 1'b1; hang_all = 1'b0;
    repeat (80) tick();
    checks++; if (rq.size() !== 0) begin errors++; $display("FAIL mid_late got %0d exp 0", rq.size()); end
    t = cyc + 1;
    send1(0, 4'd5, 32'd3, 32'd2);
    wait_rsp(1, 10, "mid_fresh");
    if (rq.size() > 0) begin
      checks++; if (rq[0].resp !== 2'b01) begin errors++; $display("FAIL mid_fresp got %b exp 01", rq[0].resp); end
      checks++; if (rq[0].data !== 32'hC) begin errors++; $display("FAIL mid_fdata got %h exp c", rq[0].data); end
      checks++; if (rq[0].cyc !== t + 4) begin errors++; $display("FAIL mid_flat got %0d exp %0d", rq[0].cyc, t + 4); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_invalid();
    test_timeout();
    test_drop_and_resp_cycle();
    test_alu_error();
    test_reset_mid();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
